writeback_unit: RTL

//  Producer side of the register-file write port: merges ALU results and in-order load responses

---
 rtl/writeback_unit_pkg.sv | 33 +++
 rtl/writeback_unit_if.sv | 34 +++
 rtl/writeback_unit_fifo.sv | 51 +++++
 rtl/writeback_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: register-write control word, load
// descriptors and formatted load results.
package writeback_unit_pkg;
  localparam int XLEN = 32;

  typedef logic [4:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  // funct3 kept as raw bits so unused encodings survive to the formatter
  typedef struct packed {
    rv_reg_t    rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } pending_load_t;

  typedef struct packed {
    rv_reg_t         rd;
    logic [XLEN-1:0] value;
  } load_result_t;
endpackage

// File: rtl/writeback_unit_if.sv
// Bus bundle between execute/memory/register_file and the writeback unit.
// master = producer/consumer side, slave = writeback_unit.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic               alu_valid;
  rv_reg_t            alu_rd;
  logic [XLEN-1:0]    alu_value;
  logic               load_issue_valid;
  logic               load_issue_ready;
  rv_reg_t            load_issue_rd;
  logic [2:0]         load_issue_funct3;
  logic [1:0]         load_issue_offset;
  logic               mem_rsp_valid;
  logic               mem_rsp_ready;
  logic [XLEN-1:0]    mem_rsp_data;
  reg_write_control_t write_control;
  logic [31:0]        rd_busy;
  logic               wb_error;

  modport master (
    output alu_valid, alu_rd, alu_value,
    output load_issue_valid, load_issue_rd, load_issue_funct3, load_issue_offset,
    output mem_rsp_valid, mem_rsp_data,
    input  load_issue_ready, mem_rsp_ready, write_control, rd_busy, wb_error
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value,
    input  load_issue_valid, load_issue_rd, load_issue_funct3, load_issue_offset,
    input  mem_rsp_valid, mem_rsp_data,
    output load_issue_ready, mem_rsp_ready, write_control, rd_busy, wb_error
  );
endinterface

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: small synchronous FIFO, head visible combinationally; push while
// full is accepted only when a pop happens on the same edge.
module wb_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and in-order load responses into one
// register write per edge. Optional per-register load scoreboard: WB_LOAD_SCOREBOARD_EN.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LOAD_DEPTH   = 4,
  parameter int RESULT_DEPTH = 2
) (
  input logic             clock,
  input logic             reset_n,
  writeback_unit_if.slave bus
);
  localparam int PCW = $clog2(LOAD_DEPTH) + 1;
  localparam int RCW = $clog2(RESULT_DEPTH) + 1;

  pending_load_t   pend_in, pend_head;
  load_result_t    res_in, res_head;
  logic            pend_push, pend_pop, pend_full, pend_empty;
  logic            res_push, res_pop, res_full, res_empty;
  logic [PCW-1:0]  pend_count;
  logic [RCW-1:0]  res_count;
  logic            rsp_accept;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] fmt_value;
  logic            unused_counts;

  assign unused_counts = ^{pend_count, res_count};

  // No bypass: a pop on a full pending queue does not open the issue port.
  assign bus.load_issue_ready = !pend_full;
  assign pend_push = bus.load_issue_valid && !pend_full;
  assign pend_in   = '{rd: bus.load_issue_rd, funct3: bus.load_issue_funct3,
                       offset: bus.load_issue_offset};

  // The ALU always wins the write port; the buffer drains only on ALU-idle edges.
  assign res_pop           = !bus.alu_valid && !res_empty;
  assign bus.mem_rsp_ready = !res_full || res_pop;
  assign rsp_accept        = bus.mem_rsp_valid && bus.mem_rsp_ready;
  assign pend_pop          = rsp_accept && !pend_empty;
  assign res_push          = pend_pop;
  assign res_in            = '{rd: pend_head.rd, value: fmt_value};

  assign byte_sel = bus.mem_rsp_data[{pend_head.offset, 3'b000} +: 8];
  assign half_sel = bus.mem_rsp_data[{pend_head.offset[1], 4'b0000} +: 16];

  always_comb begin
    fmt_value = bus.mem_rsp_data;
    case (pend_head.funct3)
      F3_LB:   fmt_value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   fmt_value = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  fmt_value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  fmt_value = {{(XLEN-16){1'b0}}, half_sel};
      default: fmt_value = bus.mem_rsp_data;
    endcase
  end

  wb_fifo #(.T(pending_load_t), .DEPTH(LOAD_DEPTH)) u_pending (
    .clock(clock), .reset_n(reset_n),
    .push(pend_push), .push_data(pend_in), .pop(pend_pop),
    .head(pend_head), .full(pend_full), .empty(pend_empty), .count(pend_count)
  );

  wb_fifo #(.T(load_result_t), .DEPTH(RESULT_DEPTH)) u_results (
    .clock(clock), .reset_n(reset_n),
    .push(res_push), .push_data(res_in), .pop(res_pop),
    .head(res_head), .full(res_full), .empty(res_empty), .count(res_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.write_control <= '0;
    end else if (bus.alu_valid) begin
      bus.write_control <= '{enable: (bus.alu_rd != '0), which_register: bus.alu_rd,
                             value: bus.alu_value};
    end else if (res_pop) begin
      bus.write_control <= '{enable: (res_head.rd != '0), which_register: res_head.rd,
                             value: res_head.value};
    end else begin
      bus.write_control.enable <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      bus.wb_error <= 1'b0;
    else if (rsp_accept && pend_empty) bus.wb_error <= 1'b1;
  end

`ifdef WB_LOAD_SCOREBOARD_EN
  localparam int BW = $clog2(LOAD_DEPTH + RESULT_DEPTH) + 1;

  logic [BW-1:0] busy_cnt [32];
  logic [31:0]   busy_inc, busy_dec;

  assign busy_inc = pend_push ? ((32'd1 << bus.load_issue_rd) & ~32'd1) : 32'd0;
  assign busy_dec = res_pop   ? ((32'd1 << res_head.rd) & ~32'd1)       : 32'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) busy_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (busy_inc[r] && !busy_dec[r])      busy_cnt[r] <= busy_cnt[r] + 1'b1;
        else if (busy_dec[r] && !busy_inc[r]) busy_cnt[r] <= busy_cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    bus.rd_busy = '0;
    for (int r = 0; r < 32; r++) bus.rd_busy[r] = (busy_cnt[r] != '0);
  end
`else
  assign bus.rd_busy = '0;
`endif
endmodule
